// File: rtl/cell_instruction_issuer.sv
// Initiator side of the CellProcessor instruction interface: assembles cellA/cellB from a
// row-major pixel stream, issues one instruction word, and returns the core's result pixel.
module cell_instruction_issuer #(
  parameter int unsigned CELL_DIM       = 3,
  parameter int unsigned PIXEL_W        = 24,
  parameter int unsigned OPCODE_W       = 4,
  parameter int unsigned RESULT_LATENCY = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [OPCODE_W-1:0]                   cmd_opcode,
  input  logic                                  cmd_unary,
  input  logic                                  pix_valid,
  output logic                                  pix_ready,
  input  logic [PIXEL_W-1:0]                    pix_data,
  output logic                                  iw_valid,
  input  logic                                  iw_ready,
  output logic [OPCODE_W-1:0]                   iw_opcode,
  output logic [CELL_DIM*CELL_DIM*PIXEL_W-1:0]  iw_cellA,
  output logic [CELL_DIM*CELL_DIM*PIXEL_W-1:0]  iw_cellB,
  input  logic [PIXEL_W-1:0]                    core_result,
  output logic                                  res_valid,
  output logic [PIXEL_W-1:0]                    res_data
);

  localparam int unsigned NPIX   = CELL_DIM * CELL_DIM;
  localparam int unsigned CELL_W = NPIX * PIXEL_W;
  localparam int unsigned CNT_W  = $clog2(NPIX);
  localparam int unsigned LAT_W  = (RESULT_LATENCY > 1) ? $clog2(RESULT_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic                unary_q, unary_d;
  logic [CELL_W-1:0]   cell_a_q, cell_a_d;
  logic [CELL_W-1:0]   cell_b_q, cell_b_d;
  logic [PIXEL_W-1:0]  res_data_q, res_data_d;
  logic                cap_q, cap_d;
  logic                res_valid_q;

  logic last_beat;
  assign last_beat = (cnt_q == CNT_W'(NPIX - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_d      = lat_q;
    op_d       = op_q;
    unary_d    = unary_q;
    cell_a_d   = cell_a_q;
    cell_b_d   = cell_b_q;
    res_data_d = res_data_q;
    cap_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d     = cmd_opcode;
          unary_d  = cmd_unary;
          cell_b_d = '0;
          cnt_d    = '0;
          state_d  = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        if (pix_valid) begin
          cell_a_d[cnt_q*PIXEL_W +: PIXEL_W] = pix_data;
          if (last_beat) begin
            cnt_d   = '0;
            state_d = unary_q ? S_ISSUE : S_LOAD_B;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_LOAD_B: begin
        if (pix_valid) begin
          cell_b_d[cnt_q*PIXEL_W +: PIXEL_W] = pix_data;
          if (last_beat) begin
            cnt_d   = '0;
            state_d = S_ISSUE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (iw_ready) begin
          lat_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // res_data is captured here; the valid pulse follows one clock later via cap_q.
        if (lat_q == LAT_W'(RESULT_LATENCY - 1)) begin
          res_data_d = core_result;
          cap_d      = 1'b1;
          state_d    = S_IDLE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lat_q       <= '0;
      op_q        <= '0;
      unary_q     <= 1'b0;
      cell_a_q    <= '0;
      cell_b_q    <= '0;
      res_data_q  <= '0;
      cap_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_q       <= lat_d;
      op_q        <= op_d;
      unary_q     <= unary_d;
      cell_a_q    <= cell_a_d;
      cell_b_q    <= cell_b_d;
      res_data_q  <= res_data_d;
      cap_q       <= cap_d;
      res_valid_q <= cap_q;
    end
  end

  // cmd_ready is gated by reset so every output reads 0 while reset is held.
  assign cmd_ready = rst && (state_q == S_IDLE);
  assign pix_ready = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign iw_valid  = (state_q == S_ISSUE);
  assign iw_opcode = op_q;
  assign iw_cellA  = cell_a_q;
  assign iw_cellB  = cell_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule
